// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory SRAM bridge: FSM states,
// bus transfer sizes and the kseg0/kseg1 window used by the optional address map.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } dmem_state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [31:0] KSEG_LO   = 32'h8000_0000;
  localparam logic [31:0] KSEG_HI   = 32'hBFFF_FFFF;
  localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

  // Unmapped kseg0/kseg1 segments alias the bottom 512 MiB of physical space.
  function automatic logic [31:0] kseg_map(input logic [31:0] vaddr);
    return (vaddr >= KSEG_LO && vaddr <= KSEG_HI) ? (vaddr & KSEG_MASK) : vaddr;
  endfunction

endpackage

// File: rtl/dmem_strobe_decode.sv
// Turns the M-stage byte strobes into bus direction, transfer size and the
// byte offset placed in the low address bits. Purely combinational.
module dmem_strobe_decode
  import dmem_bridge_pkg::*;
(
  input  logic [3:0]  memwriteEN,
  input  logic [31:0] aluoutM,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic        legal
);

  logic [3:0] onehot_hit;
  logic [1:0] byte_lane;
  logic [1:0] lane;
  logic       unused_addr_lo;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_onehot
      assign onehot_hit[gi] = (memwriteEN == (4'b0001 << gi));
    end
  endgenerate

  assign byte_lane = {onehot_hit[3] | onehot_hit[2], onehot_hit[3] | onehot_hit[1]};

  // The lane comes from the strobes; the core's low address bits are not trusted.
  assign unused_addr_lo = ^aluoutM[1:0];

  always_comb begin
    wr    = |memwriteEN;
    size  = SZ_WORD;
    lane  = 2'b00;
    legal = 1'b1;
    case (memwriteEN)
      4'b0000, 4'b1111: size = SZ_WORD;
      4'b0011:          size = SZ_HALF;
      4'b1100: begin
        size = SZ_HALF;
        lane = 2'b10;
      end
      default: begin
        if (|onehot_hit) begin
          size = SZ_BYTE;
          lane = byte_lane;
        end else begin
          legal = 1'b0;
        end
      end
    endcase
  end

  assign addr = {aluoutM[31:2], lane};

endmodule

// File: rtl/dmem_sram_bridge.sv
// Data-side bridge from the M stage onto a req/addr_ok/data_ok SRAM-like bus.
// Define DMEM_ADDR_MAP_EN to fold kseg0/kseg1 onto physical addresses.
module dmem_sram_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RDATA_RST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_sram_enM,
  input  logic [3:0]        memwriteEN,
  input  logic [31:0]       aluoutM,
  input  logic [DATA_W-1:0] writedataM,
  input  logic              longest_stall,
  output logic [DATA_W-1:0] readdataM,
  output logic              d_stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [31:0]       data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  dmem_state_e       state_reg;
  logic              flush_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic        dec_wr;
  logic [1:0]  dec_size;
  logic [31:0] dec_addr;
  logic        dec_legal;
  logic [31:0] paddr;
  logic        resp_done;
  logic        resp_keep;

  dmem_strobe_decode u_decode (
    .memwriteEN (memwriteEN),
    .aluoutM    (aluoutM),
    .wr         (dec_wr),
    .size       (dec_size),
    .addr       (dec_addr),
    .legal      (dec_legal)
  );

`ifdef DMEM_ADDR_MAP_EN
  assign paddr = kseg_map(dec_addr);
`else
  assign paddr = dec_addr;
`endif

  // A response finishes the access either straight from REQ or later from WAIT.
  assign resp_done = ((state_reg == REQ) && data_addr_ok && data_data_ok) ||
                     ((state_reg == WAIT) && data_data_ok);
  // The instruction must still be present and never have been flushed.
  assign resp_keep = data_sram_enM && !flush_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      flush_reg  <= 1'b0;
      rdata_reg  <= RDATA_RST;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= SZ_BYTE;
      data_addr  <= 32'h0000_0000;
      data_wdata <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (data_sram_enM) begin
            state_reg  <= REQ;
            flush_reg  <= 1'b0;
            data_req   <= 1'b1;
            data_wr    <= dec_wr;
            data_size  <= dec_size;
            data_addr  <= paddr;
            data_wdata <= writedataM;
          end
        end
        REQ: begin
          if (!data_sram_enM) flush_reg <= 1'b1;
          if (data_addr_ok) begin
            data_req  <= 1'b0;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (!data_sram_enM) flush_reg <= 1'b1;
        end
        DONE: begin
          if (!longest_stall) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      // Completion overrides the per-state next state chosen above.
      if (resp_done) begin
        state_reg <= resp_keep ? DONE : IDLE;
        if (resp_keep && !data_wr) rdata_reg <= data_rdata;
      end
    end
  end

  assign readdataM = rdata_reg;
  assign d_stall   = ((state_reg == IDLE) && data_sram_enM) ||
                     (state_reg == REQ) || (state_reg == WAIT);

  a_legal_strobe : assert property (@(posedge clk) disable iff (!rst)
    ((state_reg == IDLE) && data_sram_enM) |-> dec_legal);

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Randomised self-checking bench for dmem_sram_bridge with a behavioural bus
// slave and a transaction-level expectation model.
module tb_dmem_sram_bridge;

  localparam logic [31:0] RST_VAL = 32'hA5A5_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_sram_enM = 1'b0;
  logic [3:0]  memwriteEN = 4'b0000;
  logic [31:0] aluoutM = 32'h0;
  logic [31:0] writedataM = 32'h0;
  logic        longest_stall = 1'b1;
  logic [31:0] readdataM;
  logic        d_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic [31:0] data_rdata = 32'h0;

  int checks = 0;
  int failures = 0;
  logic [31:0] model_rd = RST_VAL;

  // observations from the last run_access
  int          obs_stall;
  bit          obs_done;
  logic        obs_wr;
  logic [1:0]  obs_size;
  logic [31:0] obs_addr;
  logic [31:0] obs_wdata;
  bit          obs_fields_stable;
  logic        obs_dstall_after;
  logic        obs_req_after;
  logic [31:0] obs_rd_done;
  bit          obs_rd_stable;
  bit          obs_extra_req;

  logic [3:0] strb_tab [8] = '{4'b0000, 4'b1111, 4'b0011, 4'b1100,
                               4'b0001, 4'b0010, 4'b0100, 4'b1000};

  always #5 clk = ~clk;

  dmem_sram_bridge #(.DATA_W(32), .RDATA_RST(RST_VAL)) dut (
    .clk           (clk),
    .rst           (rst),
    .data_sram_enM (data_sram_enM),
    .memwriteEN    (memwriteEN),
    .aluoutM       (aluoutM),
    .writedataM    (writedataM),
    .longest_stall (longest_stall),
    .readdataM     (readdataM),
    .d_stall       (d_stall),
    .data_req      (data_req),
    .data_wr       (data_wr),
    .data_size     (data_size),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_addr_ok  (data_addr_ok),
    .data_data_ok  (data_data_ok),
    .data_rdata    (data_rdata)
  );

  // Reference: bus size from how many bytes are enabled.
  function automatic logic [1:0] ref_size(input logic [3:0] s);
    if ($countones(s) == 1) return 2'd0;
    if (s == 4'b0011 || s == 4'b1100) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] ref_addr(input logic [3:0] s, input logic [31:0] va);
    logic [31:0] a;
    a = {va[31:2], 2'b00};
    if (ref_size(s) == 2'd1 && s[2]) a[1:0] = 2'b10;
    if (ref_size(s) == 2'd0)
      for (int i = 0; i < 4; i++) if (s[i]) a[1:0] = 2'(i);
`ifdef DMEM_ADDR_MAP_EN
    if (a[31:30] == 2'b10) a[31:29] = 3'b000;
`endif
    return a;
  endfunction

  // Drive one M-stage access and play the bus slave. Called and returns at posedge+1.
  task automatic run_access(input logic [3:0] strb, input logic [31:0] va, input logic [31:0] wd,
                            input int a_lat, input int d_lat, input logic [31:0] rv,
                            input int flush_c, input int hold);
    int c, seen, acc_c, ok_c;
    bit acc, ok, first;
    obs_stall = 0; obs_done = 0; obs_wr = 1'b0; obs_size = 2'd3; obs_addr = 32'h0;
    obs_wdata = 32'h0; obs_fields_stable = 1; obs_dstall_after = 1'bx; obs_req_after = 1'bx;
    obs_rd_done = 32'h0; obs_rd_stable = 1; obs_extra_req = 0;
    data_sram_enM = 1'b1; memwriteEN = strb; aluoutM = va; writedataM = wd; longest_stall = 1'b1;
    c = 0; seen = 0; acc_c = 0; ok_c = 0; acc = 0; ok = 0; first = 1;
    while (c < 60) begin
      if (flush_c >= 0 && c >= flush_c) data_sram_enM = 1'b0;
      @(negedge clk);
      if (ok && c == ok_c + 1) begin
        obs_done = 1; obs_dstall_after = d_stall; obs_req_after = data_req; obs_rd_done = readdataM;
        break;
      end
      if (d_stall) obs_stall++;
      if (data_req) begin
        if (first) begin
          obs_wr = data_wr; obs_size = data_size; obs_addr = data_addr; obs_wdata = data_wdata;
          first = 0;
        end else if (data_wr !== obs_wr || data_size !== obs_size ||
                     data_addr !== obs_addr || data_wdata !== obs_wdata) begin
          obs_fields_stable = 0;
        end
      end
      if (data_req && !acc) begin
        if (seen == a_lat) begin data_addr_ok = 1'b1; acc = 1; acc_c = c; end
        else seen++;
      end
      if (acc && !ok && c == acc_c + d_lat) begin
        data_data_ok = 1'b1; data_rdata = rv; ok = 1; ok_c = c;
      end
      @(posedge clk); #1;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom; c++;
    end
    if (obs_done && flush_c < 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (readdataM !== obs_rd_done) obs_rd_stable = 0;
        if (data_req !== 1'b0 || d_stall !== 1'b0) obs_extra_req = 1;
      end
      @(posedge clk); #1;
      longest_stall = 1'b0;
      @(negedge clk);
      if (readdataM !== obs_rd_done) obs_rd_stable = 0;
      if (data_req !== 1'b0 || d_stall !== 1'b0) obs_extra_req = 1;
    end
    @(posedge clk); #1;
    data_sram_enM = 1'b0; longest_stall = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (readdataM !== RST_VAL) begin failures++; $display("FAIL reset readdataM: got %h expected %h", readdataM, RST_VAL); end
    checks++; if (d_stall !== 1'b0) begin failures++; $display("FAIL reset d_stall: got %b expected 0", d_stall); end
    checks++; if (data_req !== 1'b0) begin failures++; $display("FAIL reset data_req: got %b expected 0", data_req); end
    checks++; if (data_wr !== 1'b0) begin failures++; $display("FAIL reset data_wr: got %b expected 0", data_wr); end
    checks++; if (data_size !== 2'd0) begin failures++; $display("FAIL reset data_size: got %0d expected 0", data_size); end
    checks++; if (data_addr !== 32'h0) begin failures++; $display("FAIL reset data_addr: got %h expected 0", data_addr); end
    checks++; if (data_wdata !== 32'h0) begin failures++; $display("FAIL reset data_wdata: got %h expected 0", data_wdata); end
    @(posedge clk); #1;
    rst = 1'b1;
    model_rd = RST_VAL;
  endtask

  task automatic test_word_read();
    run_access(4'b0000, 32'h0000_1004, 32'h1111_2222, 0, 2, 32'hDEAD_BEEF, -1, 3);
    checks++; if (!obs_done) begin failures++; $display("FAIL word_read done: got 0 expected 1"); end
    checks++; if (obs_size !== 2'd2) begin failures++; $display("FAIL word_read size: got %0d expected 2", obs_size); end
    checks++; if (obs_addr !== 32'h0000_1004) begin failures++; $display("FAIL word_read addr: got %h expected 00001004", obs_addr); end
    checks++; if (obs_wr !== 1'b0) begin failures++; $display("FAIL word_read wr: got %b expected 0", obs_wr); end
    checks++; if (obs_stall !== 4) begin failures++; $display("FAIL word_read stall: got %0d expected 4", obs_stall); end
    checks++; if (obs_rd_done !== 32'hDEAD_BEEF) begin failures++; $display("FAIL word_read data: got %h expected deadbeef", obs_rd_done); end
    checks++; if (obs_dstall_after !== 1'b0) begin failures++; $display("FAIL word_read stall_after: got %b expected 0", obs_dstall_after); end
    checks++; if (!obs_rd_stable) begin failures++; $display("FAIL word_read hold: got unstable expected stable"); end
    model_rd = 32'hDEAD_BEEF;
    $display("txn word_read addr=%h data=%h stall=%0d", obs_addr, obs_rd_done, obs_stall);
  endtask

  task automatic test_byte_store();
    run_access(4'b0100, 32'h0000_2003, 32'h00AB_0000, 1, 1, 32'h5555_5555, -1, 1);
    checks++; if (obs_wr !== 1'b1) begin failures++; $display("FAIL byte_store wr: got %b expected 1", obs_wr); end
    checks++; if (obs_size !== 2'd0) begin failures++; $display("FAIL byte_store size: got %0d expected 0", obs_size); end
    checks++; if (obs_addr !== 32'h0000_2002) begin failures++; $display("FAIL byte_store addr: got %h expected 00002002", obs_addr); end
    checks++; if (obs_wdata !== 32'h00AB_0000) begin failures++; $display("FAIL byte_store wdata: got %h expected 00ab0000", obs_wdata); end
    checks++; if (obs_stall !== 4 || obs_dstall_after !== 1'b0) begin failures++; $display("FAIL byte_store stall: got %0d/%b expected 4/0", obs_stall, obs_dstall_after); end
    checks++; if (obs_rd_done !== model_rd) begin failures++; $display("FAIL byte_store readdata: got %h expected %h", obs_rd_done, model_rd); end
    $display("txn byte_store addr=%h wdata=%h stall=%0d", obs_addr, obs_wdata, obs_stall);
  endtask

  task automatic test_zero_latency();
    logic [31:0] rv;
    rv = $urandom;
    run_access(4'b0000, 32'h0000_0040, 32'h0, 0, 0, rv, -1, 0);
    checks++; if (obs_stall !== 2) begin failures++; $display("FAIL zero_lat stall: got %0d expected 2", obs_stall); end
    checks++; if (obs_rd_done !== rv) begin failures++; $display("FAIL zero_lat data: got %h expected %h", obs_rd_done, rv); end
    model_rd = rv;
    $display("txn zero_latency data=%h stall=%0d", obs_rd_done, obs_stall);
  endtask

  task automatic test_hold();
    logic [31:0] rv;
    rv = $urandom;
    run_access(4'b0000, 32'h0000_0080, 32'h0, 1, 2, rv, -1, 5);
    checks++; if (!obs_rd_stable || obs_rd_done !== rv) begin failures++; $display("FAIL hold data: got %h stable=%0d expected %h", obs_rd_done, obs_rd_stable, rv); end
    checks++; if (obs_extra_req) begin failures++; $display("FAIL hold extra_req: got 1 expected 0"); end
    model_rd = rv;
    $display("txn hold data=%h", obs_rd_done);
  endtask

  task automatic test_flush();
    logic [31:0] rv;
    int a_tab [2] = '{0, 2};
    int d_tab [2] = '{3, 1};
    int f_tab [2] = '{3, 1};
    for (int k = 0; k < 2; k++) begin
      rv = $urandom;
      run_access(4'b0000, 32'h0000_0100, 32'h0, a_tab[k], d_tab[k], rv, f_tab[k], 0);
      checks++; if (obs_stall !== 2 + a_tab[k] + d_tab[k]) begin failures++; $display("FAIL flush%0d stall: got %0d expected %0d", k, obs_stall, 2 + a_tab[k] + d_tab[k]); end
      checks++; if (obs_dstall_after !== 1'b0 || obs_req_after !== 1'b0) begin failures++; $display("FAIL flush%0d after: got stall=%b req=%b expected 0/0", k, obs_dstall_after, obs_req_after); end
      checks++; if (obs_rd_done !== model_rd) begin failures++; $display("FAIL flush%0d readdata: got %h expected %h", k, obs_rd_done, model_rd); end
      $display("txn flush%0d stall=%0d readdata=%h", k, obs_stall, obs_rd_done);
      // immediately follow with a fresh read: only possible if the FSM is back in IDLE
      rv = $urandom;
      run_access(4'b0000, 32'h0000_0200, 32'h0, 0, 1, rv, -1, 0);
      checks++; if (obs_stall !== 3 || obs_rd_done !== rv) begin failures++; $display("FAIL flush%0d follow: got stall=%0d data=%h expected 3/%h", k, obs_stall, obs_rd_done, rv); end
      model_rd = rv;
    end
  endtask

  task automatic test_addr_map();
    logic [31:0] va_tab [6] = '{32'hBFC0_0010, 32'h8000_0000, 32'hBFFF_FFFC,
                                32'hC000_0000, 32'h7FFF_FFFC, 32'hA000_1234};
    logic [31:0] exp_direct;
`ifdef DMEM_ADDR_MAP_EN
    exp_direct = 32'h1FC0_0010;
`else
    exp_direct = 32'hBFC0_0010;
`endif
    for (int k = 0; k < 6; k++) begin
      run_access(4'b0000, va_tab[k], 32'h0, 0, 0, model_rd, -1, 0);
      checks++; if (obs_addr !== ref_addr(4'b0000, va_tab[k])) begin failures++; $display("FAIL addr_map%0d: got %h expected %h", k, obs_addr, ref_addr(4'b0000, va_tab[k])); end
      if (k == 0) begin
        checks++; if (obs_addr !== exp_direct) begin failures++; $display("FAIL addr_map bfc00010: got %h expected %h", obs_addr, exp_direct); end
      end
      $display("txn addr_map va=%h pa=%h", va_tab[k], obs_addr);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rv;
    data_sram_enM = 1'b1; memwriteEN = 4'b0000; aluoutM = 32'h0000_3000; longest_stall = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    data_sram_enM = 1'b0; rst = 1'b0;
    #1;
    checks++; if (data_req !== 1'b0 || d_stall !== 1'b0) begin failures++; $display("FAIL reset_mid bus: got req=%b stall=%b expected 0/0", data_req, d_stall); end
    checks++; if (readdataM !== RST_VAL) begin failures++; $display("FAIL reset_mid readdataM: got %h expected %h", readdataM, RST_VAL); end
    @(posedge clk); #1;
    rst = 1'b1;
    model_rd = RST_VAL;
    rv = $urandom;
    run_access(4'b0000, 32'h0000_3000, 32'h0, 1, 0, rv, -1, 0);
    checks++; if (obs_stall !== 3 || obs_rd_done !== rv) begin failures++; $display("FAIL reset_mid follow: got stall=%0d data=%h expected 3/%h", obs_stall, obs_rd_done, rv); end
    model_rd = rv;
    $display("txn reset_mid follow data=%h", obs_rd_done);
  endtask

  task automatic test_random();
    logic [3:0]  strb;
    logic [31:0] va, wd, rv, exp_rd;
    int a, d, hold, fl;
    for (int n = 0; n < 40; n++) begin
      strb = strb_tab[$urandom_range(0, 7)];
      va = $urandom; wd = $urandom; rv = $urandom;
      a = $urandom_range(0, 3); d = $urandom_range(0, 3); hold = $urandom_range(0, 2);
      fl = -1;
      if ($urandom_range(0, 5) == 0) fl = $urandom_range(1, 1 + a + d);
      run_access(strb, va, wd, a, d, rv, fl, hold);
      exp_rd = (fl < 0 && strb == 4'b0000) ? rv : model_rd;
      checks++; if (!obs_done) begin failures++; $display("FAIL rnd%0d done: got 0 expected 1", n); end
      checks++; if (obs_stall !== 2 + a + d) begin failures++; $display("FAIL rnd%0d stall: got %0d expected %0d", n, obs_stall, 2 + a + d); end
      checks++; if (obs_size !== ref_size(strb) || obs_wr !== (strb != 4'b0000)) begin failures++; $display("FAIL rnd%0d size/wr: got %0d/%b expected %0d/%b", n, obs_size, obs_wr, ref_size(strb), strb != 4'b0000); end
      checks++; if (obs_addr !== ref_addr(strb, va)) begin failures++; $display("FAIL rnd%0d addr: got %h expected %h", n, obs_addr, ref_addr(strb, va)); end
      checks++; if (obs_wdata !== wd || !obs_fields_stable) begin failures++; $display("FAIL rnd%0d wdata: got %h stable=%0d expected %h", n, obs_wdata, obs_fields_stable, wd); end
      checks++; if (obs_dstall_after !== 1'b0) begin failures++; $display("FAIL rnd%0d stall_after: got %b expected 0", n, obs_dstall_after); end
      checks++; if (obs_rd_done !== exp_rd || !obs_rd_stable || obs_extra_req) begin failures++; $display("FAIL rnd%0d readdata: got %h stable=%0d extra=%0d expected %h", n, obs_rd_done, obs_rd_stable, obs_extra_req, exp_rd); end
      model_rd = exp_rd;
      $display("txn rnd%0d strb=%b va=%h a=%0d d=%0d flush=%0d stall=%0d rd=%h", n, strb, va, a, d, fl, obs_stall, obs_rd_done);
    end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_store();
    test_zero_latency();
    test_hold();
    test_flush();
    test_addr_map();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
